// File: rtl/pcie_completion_timeout_tracker.sv
// Per-tag completion-timeout tracker for outstanding PCIe non-posted requests.
// Each tag holds a down-counter loaded at request accept. A tag retires on its final
// completion, or it expires and is reported one tag at a time until acknowledged.
module pcie_completion_timeout_tracker #(
   parameter int unsigned NUM_TAGS = 8,
   parameter int unsigned TAG_W    = 3,
   parameter int unsigned CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [CNT_W-1:0] timeout_value,
   input  logic             enable,
   input  logic             req_valid,
   input  logic [TAG_W-1:0] req_tag,
   output logic             req_ready,
   input  logic             cpl_valid,
   input  logic [TAG_W-1:0] cpl_tag,
   input  logic             cpl_last,
   output logic             timeout_valid,
   output logic [TAG_W-1:0] timeout_tag,
   input  logic             timeout_ack,
   output logic [TAG_W:0]   outstanding_cnt,
   output logic             err_unexpected_cpl
);

   typedef enum logic [1:0] {StIdle, StPending, StExpired} tag_state_e;

   localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
   localparam logic [TAG_W:0]   OccOne = (TAG_W + 1)'(1);

   tag_state_e       state_q [NUM_TAGS];
   tag_state_e       state_d [NUM_TAGS];
   logic [CNT_W-1:0] cnt_q   [NUM_TAGS];
   logic [CNT_W-1:0] cnt_d   [NUM_TAGS];

   logic             ready_en_q;
   logic             tv_q, tv_d;
   logic [TAG_W-1:0] tt_q, tt_d;
   logic [TAG_W:0]   occ_q, occ_d;
   logic             err_q, err_d;

   logic             any_exp;
   logic [TAG_W-1:0] low_idx;
   logic             accept;
   logic [CNT_W-1:0] load_val;

   // Ready is held low until the first edge after reset release.
   assign req_ready = enable & ready_en_q & (state_q[req_tag] == StIdle);
   assign accept    = req_valid & req_ready;
   // A zero timeout would never expire; treat it as one cycle.
   assign load_val  = (timeout_value == '0) ? CntOne : timeout_value;

   // Per-tag next state and counter.
   always_comb begin
      for (int i = 0; i < NUM_TAGS; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         unique case (state_q[i])
            StIdle: begin
               if (accept && (req_tag == TAG_W'(i))) begin
                  state_d[i] = StPending;
                  cnt_d[i]   = load_val;
               end
            end
            StPending: begin
               // A final completion beats a same-cycle expiry.
               if (cpl_valid && cpl_last && (cpl_tag == TAG_W'(i))) begin
                  state_d[i] = StIdle;
                  cnt_d[i]   = '0;
               end else if (cnt_q[i] == CntOne) begin
                  state_d[i] = StExpired;
                  cnt_d[i]   = '0;
               end else begin
                  cnt_d[i] = cnt_q[i] - CntOne;
               end
            end
            StExpired: begin
               if (tv_q && timeout_ack && (tt_q == TAG_W'(i))) begin
                  state_d[i] = StIdle;
               end
            end
            default: state_d[i] = StIdle;
         endcase
      end
   end

   // Lowest-index expired tag and occupancy count from registered state.
   always_comb begin
      any_exp = 1'b0;
      low_idx = '0;
      occ_d   = '0;
      for (int i = NUM_TAGS - 1; i >= 0; i--) begin
         if (state_q[i] == StExpired) begin
            any_exp = 1'b1;
            low_idx = TAG_W'(i);
         end
         if (state_q[i] != StIdle) begin
            occ_d = occ_d + OccOne;
         end
      end
   end

   // Timeout report handshake and unexpected-completion flag.
   always_comb begin
      tv_d  = tv_q;
      tt_d  = tt_q;
      err_d = cpl_valid & (state_q[cpl_tag] != StPending);
      if (tv_q) begin
         if (timeout_ack) begin
            tv_d = 1'b0;
         end
      end else if (any_exp) begin
         tv_d = 1'b1;
         tt_d = low_idx;
      end
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_TAGS; i++) begin
            state_q[i] <= StIdle;
            cnt_q[i]   <= '0;
         end
         ready_en_q <= 1'b0;
         tv_q       <= 1'b0;
         tt_q       <= '0;
         occ_q      <= '0;
         err_q      <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_TAGS; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
         ready_en_q <= 1'b1;
         tv_q       <= tv_d;
         tt_q       <= tt_d;
         occ_q      <= occ_d;
         err_q      <= err_d;
      end
   end

   assign timeout_valid      = tv_q;
   assign timeout_tag        = tt_q;
   assign outstanding_cnt    = occ_q;
   assign err_unexpected_cpl = err_q;

endmodule

// File: tb/tb_pcie_completion_timeout_tracker.sv
// Directed self-checking bench for pcie_completion_timeout_tracker.
module tb_pcie_completion_timeout_tracker;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] timeout_value;
   logic        enable;
   logic        req_valid;
   logic [2:0]  req_tag;
   logic        req_ready;
   logic        cpl_valid;
   logic [2:0]  cpl_tag;
   logic        cpl_last;
   logic        timeout_valid;
   logic [2:0]  timeout_tag;
   logic        timeout_ack;
   logic [3:0]  outstanding_cnt;
   logic        err_unexpected_cpl;

   int checks   = 0;
   int failures = 0;

   pcie_completion_timeout_tracker #(
      .NUM_TAGS(8),
      .TAG_W   (3),
      .CNT_W   (32)
   ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .timeout_value     (timeout_value),
      .enable            (enable),
      .req_valid         (req_valid),
      .req_tag           (req_tag),
      .req_ready         (req_ready),
      .cpl_valid         (cpl_valid),
      .cpl_tag           (cpl_tag),
      .cpl_last          (cpl_last),
      .timeout_valid     (timeout_valid),
      .timeout_tag       (timeout_tag),
      .timeout_ack       (timeout_ack),
      .outstanding_cnt   (outstanding_cnt),
      .err_unexpected_cpl(err_unexpected_cpl)
   );

   always #5 clk = ~clk;

   // Advance n rising edges, landing 1ns after the last one.
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0; enable = 1'b1; timeout_value = 32'd16;
      req_valid = 1'b0; req_tag = 3'd0; cpl_valid = 1'b0; cpl_tag = 3'd0;
      cpl_last = 1'b0; timeout_ack = 1'b0;
      #3;
      checks++;
      if ({req_ready, timeout_valid, timeout_tag, outstanding_cnt, err_unexpected_cpl} !== 10'd0) begin
         failures++;
         $display("FAIL reset_outputs: got rdy=%b tv=%b tag=%0d occ=%0d err=%b, expected all 0",
                  req_ready, timeout_valid, timeout_tag, outstanding_cnt, err_unexpected_cpl);
      end
      rst_n = 1'b1;
      tick(2);
   endtask

   task automatic test_basic_timeout;
      timeout_value = 32'd16; req_tag = 3'd3; req_valid = 1'b1;
      checks++;
      if (req_ready !== 1'b1) begin
         failures++; $display("FAIL t1_ready: got %b expected 1", req_ready);
      end
      tick(1);                               // edge E
      req_valid = 1'b0;
      tick(1);                               // E+1
      checks++;
      if (outstanding_cnt !== 4'd1) begin
         failures++; $display("FAIL t1_occ1: got %0d expected 1", outstanding_cnt);
      end
      tick(15);                              // E+16, tag expires on this edge
      checks++;
      if (timeout_valid !== 1'b0) begin
         failures++; $display("FAIL t1_early: got tv=%b expected 0", timeout_valid);
      end
      tick(1);                               // E+17
      checks++;
      if (timeout_valid !== 1'b1 || timeout_tag !== 3'd3) begin
         failures++;
         $display("FAIL t1_report: got tv=%b tag=%0d expected tv=1 tag=3", timeout_valid, timeout_tag);
      end
      checks++;
      if (req_ready !== 1'b0) begin
         failures++; $display("FAIL t1_expired_reuse: got rdy=%b expected 0", req_ready);
      end
      tick(3);
      checks++;
      if (timeout_valid !== 1'b1 || timeout_tag !== 3'd3) begin
         failures++;
         $display("FAIL t1_hold: got tv=%b tag=%0d expected tv=1 tag=3", timeout_valid, timeout_tag);
      end
      timeout_ack = 1'b1;
      tick(1);
      timeout_ack = 1'b0;
      checks++;
      if (timeout_valid !== 1'b0) begin
         failures++; $display("FAIL t1_ack_drop: got tv=%b expected 0", timeout_valid);
      end
      tick(1);
      checks++;
      if (outstanding_cnt !== 4'd0 || req_ready !== 1'b1) begin
         failures++;
         $display("FAIL t1_retire: got occ=%0d rdy=%b expected occ=0 rdy=1", outstanding_cnt, req_ready);
      end
   endtask

   task automatic test_completion;
      timeout_value = 32'd100; req_tag = 3'd0; req_valid = 1'b1;
      tick(1);                               // edge E
      req_valid = 1'b0;
      tick(9);
      cpl_valid = 1'b1; cpl_tag = 3'd0; cpl_last = 1'b0;
      tick(1);                               // E+10
      cpl_valid = 1'b0;
      checks++;
      if (err_unexpected_cpl !== 1'b0 || outstanding_cnt !== 4'd1) begin
         failures++;
         $display("FAIL t2_partial: got err=%b occ=%0d expected err=0 occ=1",
                  err_unexpected_cpl, outstanding_cnt);
      end
      tick(29);
      cpl_valid = 1'b1; cpl_last = 1'b1;
      tick(1);                               // E+40
      cpl_valid = 1'b0; cpl_last = 1'b0;
      tick(1);
      checks++;
      if (outstanding_cnt !== 4'd0 || req_ready !== 1'b1) begin
         failures++;
         $display("FAIL t2_retire: got occ=%0d rdy=%b expected occ=0 rdy=1", outstanding_cnt, req_ready);
      end
      tick(80);
      checks++;
      if (timeout_valid !== 1'b0) begin
         failures++; $display("FAIL t2_no_timeout: got tv=%b expected 0", timeout_valid);
      end
   endtask

   task automatic test_priority;
      // Tag 5 with 9 then tag 2 with 8 one cycle later: both expire on the same edge.
      timeout_value = 32'd9; req_tag = 3'd5; req_valid = 1'b1;
      tick(1);                               // edge E
      timeout_value = 32'd8; req_tag = 3'd2;
      tick(1);                               // E+1
      req_valid = 1'b0;
      tick(8);                               // E+9, both expire
      checks++;
      if (timeout_valid !== 1'b0) begin
         failures++; $display("FAIL t3_early: got tv=%b expected 0", timeout_valid);
      end
      tick(1);                               // E+10
      checks++;
      if (timeout_valid !== 1'b1 || timeout_tag !== 3'd2 || outstanding_cnt !== 4'd2) begin
         failures++;
         $display("FAIL t3_first: got tv=%b tag=%0d occ=%0d expected tv=1 tag=2 occ=2",
                  timeout_valid, timeout_tag, outstanding_cnt);
      end
      tick(10);
      checks++;
      if (timeout_valid !== 1'b1 || timeout_tag !== 3'd2) begin
         failures++;
         $display("FAIL t3_hold: got tv=%b tag=%0d expected tv=1 tag=2", timeout_valid, timeout_tag);
      end
      timeout_ack = 1'b1;
      tick(1);
      timeout_ack = 1'b0;
      checks++;
      if (timeout_valid !== 1'b0) begin
         failures++; $display("FAIL t3_gap: got tv=%b expected 0", timeout_valid);
      end
      tick(1);
      checks++;
      if (timeout_valid !== 1'b1 || timeout_tag !== 3'd5) begin
         failures++;
         $display("FAIL t3_second: got tv=%b tag=%0d expected tv=1 tag=5", timeout_valid, timeout_tag);
      end
      timeout_ack = 1'b1;
      tick(1);
      timeout_ack = 1'b0;
      tick(2);
      checks++;
      if (outstanding_cnt !== 4'd0 || timeout_valid !== 1'b0) begin
         failures++;
         $display("FAIL t3_drain: got occ=%0d tv=%b expected occ=0 tv=0", outstanding_cnt, timeout_valid);
      end
   endtask

   task automatic test_race_and_unexpected;
      timeout_value = 32'd20; req_tag = 3'd1; req_valid = 1'b1;
      tick(1);                               // edge E
      req_valid = 1'b0;
      tick(19);                              // counter now 1
      cpl_valid = 1'b1; cpl_tag = 3'd1; cpl_last = 1'b1;
      tick(1);                               // E+20, completion wins
      cpl_valid = 1'b0; cpl_last = 1'b0;
      checks++;
      if (err_unexpected_cpl !== 1'b0) begin
         failures++; $display("FAIL t4_race_err: got err=%b expected 0", err_unexpected_cpl);
      end
      tick(3);
      checks++;
      if (timeout_valid !== 1'b0 || outstanding_cnt !== 4'd0 || req_ready !== 1'b1) begin
         failures++;
         $display("FAIL t4_race: got tv=%b occ=%0d rdy=%b expected tv=0 occ=0 rdy=1",
                  timeout_valid, outstanding_cnt, req_ready);
      end
      cpl_valid = 1'b1; cpl_tag = 3'd7; cpl_last = 1'b1;
      tick(1);
      cpl_valid = 1'b0; cpl_last = 1'b0;
      checks++;
      if (err_unexpected_cpl !== 1'b1) begin
         failures++; $display("FAIL t4_err_pulse: got err=%b expected 1", err_unexpected_cpl);
      end
      tick(1);
      checks++;
      if (err_unexpected_cpl !== 1'b0) begin
         failures++; $display("FAIL t4_err_width: got err=%b expected 0", err_unexpected_cpl);
      end
   endtask

   task automatic test_sample_and_zero;
      timeout_value = 32'd50; req_tag = 3'd4; req_valid = 1'b1;
      tick(1);                               // edge E
      req_valid = 1'b0; timeout_value = 32'd5;
      tick(50);                              // E+50, expires here
      checks++;
      if (timeout_valid !== 1'b0) begin
         failures++; $display("FAIL t5_early: got tv=%b expected 0", timeout_valid);
      end
      tick(1);                               // E+51
      checks++;
      if (timeout_valid !== 1'b1 || timeout_tag !== 3'd4) begin
         failures++;
         $display("FAIL t5_sampled: got tv=%b tag=%0d expected tv=1 tag=4", timeout_valid, timeout_tag);
      end
      timeout_ack = 1'b1;
      tick(1);
      timeout_ack = 1'b0;
      timeout_value = 32'd0; req_tag = 3'd6; req_valid = 1'b1;
      tick(1);                               // edge F
      req_valid = 1'b0;
      tick(1);                               // F+1, expires here
      checks++;
      if (timeout_valid !== 1'b0) begin
         failures++; $display("FAIL t5_zero_early: got tv=%b expected 0", timeout_valid);
      end
      tick(1);                               // F+2
      checks++;
      if (timeout_valid !== 1'b1 || timeout_tag !== 3'd6) begin
         failures++;
         $display("FAIL t5_zero: got tv=%b tag=%0d expected tv=1 tag=6", timeout_valid, timeout_tag);
      end
      timeout_ack = 1'b1;
      tick(1);
      timeout_ack = 1'b0;
      tick(2);
   endtask

   task automatic test_busy_and_reset;
      timeout_value = 32'd100; req_tag = 3'd6; req_valid = 1'b1;
      tick(1);
      checks++;
      if (req_ready !== 1'b0) begin
         failures++; $display("FAIL t6_busy: got rdy=%b expected 0", req_ready);
      end
      enable = 1'b0; req_tag = 3'd0;
      #1;
      checks++;
      if (req_ready !== 1'b0) begin
         failures++; $display("FAIL t6_enable: got rdy=%b expected 0", req_ready);
      end
      enable = 1'b1;
      tick(1);                               // tag 0 accepted
      req_tag = 3'd1;
      tick(1);                               // tag 1 accepted
      req_valid = 1'b0;
      tick(1);
      checks++;
      if (outstanding_cnt !== 4'd3) begin
         failures++; $display("FAIL t6_occ3: got %0d expected 3", outstanding_cnt);
      end
      rst_n = 1'b0;
      #2;
      checks++;
      if ({req_ready, timeout_valid, timeout_tag, outstanding_cnt, err_unexpected_cpl} !== 10'd0) begin
         failures++;
         $display("FAIL t6_reset: got rdy=%b tv=%b tag=%0d occ=%0d err=%b, expected all 0",
                  req_ready, timeout_valid, timeout_tag, outstanding_cnt, err_unexpected_cpl);
      end
      tick(2);
      rst_n = 1'b1;
      tick(150);
      checks++;
      if (timeout_valid !== 1'b0 || outstanding_cnt !== 4'd0) begin
         failures++;
         $display("FAIL t6_after_reset: got tv=%b occ=%0d expected tv=0 occ=0",
                  timeout_valid, outstanding_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_basic_timeout();
      test_completion();
      test_priority();
      test_race_and_unexpected();
      test_sample_and_zero();
      test_busy_and_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
